// File: rtl/ser4_tx_pkg.sv
// Shared constants and state encoding for the 4-bit serializer.
package ser4_tx_pkg;

  localparam int unsigned WORD_W = 4;
  localparam int unsigned CNT_W  = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/ser4_tx_mux4_1.sv
// 4:1 single-bit multiplexer selecting one bit of a word.
module mux4_1
  import ser4_tx_pkg::*;
(
  input  logic [WORD_W-1:0] data_in,
  input  logic [CNT_W-1:0]  sel_in,
  output logic              data_out
);

  // Select the addressed bit
  always_comb begin
    data_out = data_in[sel_in];
  end

endmodule

// File: rtl/ser4_tx.sv
// 4-bit parallel-to-serial transmitter with valid/ready on both sides.
module ser4_tx
  import ser4_tx_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              load_in,
  input  logic [WORD_W-1:0] data_in,
  output logic              ready_out,
  input  logic              ready_in,
  output logic              valid_out,
  output logic              serial_out,
  output logic [CNT_W-1:0]  sel_out,
  output logic              done_out
);

  state_t             r_state;
  logic [WORD_W-1:0]  r_word;
  logic [CNT_W-1:0]   r_cnt;

  state_t             w_state_nxt;
  logic [WORD_W-1:0]  w_word_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_beat;
  logic               w_last;
  logic               w_mux_bit;

  // Handshake qualifiers: a consumed beat, and the consumed final beat
  assign w_beat = valid_out & ready_in;
  assign w_last = w_beat & (r_cnt == CNT_LAST);

  // Output decode from registered state; ready reopens on the consumed last beat
  assign valid_out  = (r_state == SHIFT);
  assign ready_out  = (r_state == IDLE) | ((r_state == SHIFT) & (r_cnt == CNT_LAST) & ready_in);
  assign sel_out    = LSB_FIRST ? r_cnt : ~r_cnt;
  assign done_out   = w_last;
  assign serial_out = (r_state == SHIFT) & w_mux_bit;

  // Bit selection from the held word
  mux4_1 u_mux (
    .data_in  (r_word),
    .sel_in   (sel_out),
    .data_out (w_mux_bit)
  );

  // Next-state, word capture and beat counting
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (load_in) begin
          w_state_nxt = SHIFT;
          w_word_nxt  = data_in;
          w_cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          if (load_in) begin
            w_word_nxt  = data_in;
            w_state_nxt = SHIFT;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_beat) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, word and counter registers with synchronous reset
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule
